// File: rtl/btb_update_controller_pkg.sv
// Shared types for the BTB update controller: entry layout, index type,
// queued allocation payload, controller state and the PC-to-index hash.
// Widths come from the BTB_SIZE / ADDRESS_SIZE / INSTRUCTION_SIZE macros,
// with local defaults when the build does not supply them.

`ifndef BTB_SIZE
`define BTB_SIZE 64
`endif
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif

package btb_update_controller_pkg;

    localparam int unsigned BTB_SIZE = `BTB_SIZE;
    localparam int unsigned ADDR_W   = `ADDRESS_SIZE;
    localparam int unsigned INSTR_W  = `INSTRUCTION_SIZE;
    localparam int unsigned IDX_W    = $clog2(BTB_SIZE);

    typedef logic [IDX_W-1:0] btb_index_t;

    // One BTB entry as written through the update port
    typedef struct packed {
        logic               valid;
        logic               taken;
        logic [INSTR_W-1:0] instruction;
        logic [ADDR_W-1:0]  address;
        logic [ADDR_W-1:0]  jump_location;
    } branch;

    // Speculative allocation waiting for a free write slot
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  target;
        logic [INSTR_W-1:0] instruction;
        logic               taken;
    } alloc_req_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Word-aligned PC folded onto the BTB: pc[IDX_W+1:2]
    function automatic btb_index_t pc_to_index(input logic [ADDR_W-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

endpackage

// File: rtl/btb_alloc_fifo.sv
// Allocation queue: FIFO of alloc_req_t with a per-entry live bit that can be
// cleared by BTB index, so a retired branch can kill stale speculative
// allocations still waiting in the queue. Flush empties it in one cycle.

module btb_alloc_fifo
    import btb_update_controller_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  alloc_req_t push_data,
    input  logic       pop,
    input  logic       flush,
    input  logic       inv_en,
    input  btb_index_t inv_index,
    output alloc_req_t head_data,
    output logic       head_valid,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    alloc_req_t        mem [DEPTH];
    logic [DEPTH-1:0]  live_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;
    logic              push_killed;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign do_push     = push && !full && !flush;
    assign do_pop      = pop && !empty && !flush;
    assign head_data   = mem[rd_ptr_q];
    assign head_valid  = live_q[rd_ptr_q];
    // An entry pushed in the same cycle as a matching resolve is already stale
    assign push_killed = inv_en && (pc_to_index(push_data.pc) == inv_index);

    // Payload storage, no reset needed: occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers, occupancy and live bits
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (inv_en && (pc_to_index(mem[i].pc) == inv_index)) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (do_push) begin
                live_q[wr_ptr_q] <= !push_killed;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/btb_update_controller.sv
// BTB update controller: arbitrates the single BTB write port between retire
// resolves (always win), queued speculative allocations and, when
// BTB_INIT_SWEEP_EN is defined, a post-reset sweep that writes valid=0 to
// every index. Without BTB_INIT_SWEEP_EN the controller starts in RUN.

module btb_update_controller
    import btb_update_controller_pkg::*;
#(
    parameter int unsigned ALLOC_DEPTH = 4
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    input  logic [ADDR_W-1:0]  alloc_pc,
    input  logic [ADDR_W-1:0]  alloc_target,
    input  logic [INSTR_W-1:0] alloc_instruction,
    input  logic               alloc_taken,
    input  logic               resolve_valid,
    input  logic [ADDR_W-1:0]  resolve_pc,
    input  logic [ADDR_W-1:0]  resolve_target,
    input  logic [INSTR_W-1:0] resolve_instruction,
    input  logic               resolve_taken,
    input  logic               flush,
    output logic               btb_we,
    output logic [IDX_W-1:0]   btb_index,
    output branch              btb_entry,
    output logic               init_busy
);

`ifdef BTB_INIT_SWEEP_EN
    localparam state_e RESET_STATE = ST_INIT;
`else
    localparam state_e RESET_STATE = ST_RUN;
`endif

    state_e     state_q;
    state_e     state_d;
    logic       we_d;
    btb_index_t index_d;
    branch      entry_d;

    logic       run;
    logic       resolve_go;
    logic       accept;
    logic       bypass;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       head_valid;
    alloc_req_t head_data;
    alloc_req_t alloc_req;

`ifdef BTB_INIT_SWEEP_EN
    btb_index_t sweep_q;
    btb_index_t sweep_d;
`endif

    assign run         = (state_q == ST_RUN);
    assign alloc_ready = run && !fifo_full;
    assign resolve_go  = run && resolve_valid;
    assign accept      = alloc_valid && alloc_ready && !flush;
    // An alloc into an empty queue with a free port skips the queue entirely
    assign bypass      = accept && !resolve_go && fifo_empty;
    assign fifo_push   = accept && !bypass;

    assign alloc_req.pc          = alloc_pc;
    assign alloc_req.target      = alloc_target;
    assign alloc_req.instruction = alloc_instruction;
    assign alloc_req.taken       = alloc_taken;

`ifdef BTB_INIT_SWEEP_EN
    assign init_busy = (state_q == ST_INIT);
`else
    assign init_busy = 1'b0;
`endif

    btb_alloc_fifo #(
        .DEPTH (ALLOC_DEPTH)
    ) u_alloc_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (alloc_req),
        .pop        (fifo_pop),
        .flush      (flush),
        .inv_en     (resolve_go),
        .inv_index  (pc_to_index(resolve_pc)),
        .head_data  (head_data),
        .head_valid (head_valid),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Next-state and write-port arbitration: sweep, then resolve, then queue
    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        index_d  = btb_index;
        entry_d  = btb_entry;
        fifo_pop = 1'b0;
`ifdef BTB_INIT_SWEEP_EN
        sweep_d  = sweep_q;
`endif

        if (resolve_go) begin
            we_d                  = 1'b1;
            index_d               = pc_to_index(resolve_pc);
            entry_d.valid         = 1'b1;
            entry_d.taken         = resolve_taken;
            entry_d.instruction   = resolve_instruction;
            entry_d.address       = resolve_pc;
            entry_d.jump_location = resolve_target;
        end else if (run && !flush && !fifo_empty) begin
            fifo_pop = 1'b1;
            if (head_valid) begin
                we_d                  = 1'b1;
                index_d               = pc_to_index(head_data.pc);
                entry_d.valid         = 1'b1;
                entry_d.taken         = head_data.taken;
                entry_d.instruction   = head_data.instruction;
                entry_d.address       = head_data.pc;
                entry_d.jump_location = head_data.target;
            end
        end else if (bypass) begin
            we_d                  = 1'b1;
            index_d               = pc_to_index(alloc_pc);
            entry_d.valid         = 1'b1;
            entry_d.taken         = alloc_taken;
            entry_d.instruction   = alloc_instruction;
            entry_d.address       = alloc_pc;
            entry_d.jump_location = alloc_target;
        end

`ifdef BTB_INIT_SWEEP_EN
        if (state_q == ST_INIT) begin
            we_d    = 1'b1;
            index_d = sweep_q;
            entry_d = '0;
            sweep_d = sweep_q + btb_index_t'(1);
            if (sweep_q == btb_index_t'(BTB_SIZE - 1)) begin
                state_d = ST_RUN;
            end
        end
`endif
    end

    // State and registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            btb_we    <= 1'b0;
            btb_index <= '0;
            btb_entry <= '0;
        end else begin
            state_q   <= state_d;
            btb_we    <= we_d;
            btb_index <= index_d;
            btb_entry <= entry_d;
        end
    end

`ifdef BTB_INIT_SWEEP_EN
    // Sweep index counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_q <= '0;
        end else begin
            sweep_q <= sweep_d;
        end
    end
`endif

endmodule
